data_mem_be: RTL and testbench
==============================

DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL have parameter DEPTH, default 256, data memory size in 32-bit words; power of two, 16 to 65536.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH)+2, number of byte-address bits decoded.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, LSB-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, response present.
REQ-012 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-013 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, misaligned, illegal funct3 or out-of-range access.

Function
REQ-015 SHALL transfer a request when req_valid and req_ready are both 1 on a rising edge; likewise a response when rsp_valid and rsp_ready are both 1.
REQ-016 SHALL implement FSM with states IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-017 SHALL move IDLE->RESP on request transfer and RESP->IDLE on response transfer; otherwise hold state.
REQ-018 SHALL hold rsp_rdata and rsp_err stable while in RESP, regardless of request inputs.
REQ-019 SHALL give 1-cycle latency: response visible the cycle after acceptance; maximum throughput is one transaction per 2 cycles.
REQ-020 SHALL use word index req_addr[AW-1:2] and lane offset req_addr[1:0].
REQ-021 SHALL flag as error: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; any stores with funct3 100/101; req_addr[31:AW]!=0.
REQ-022 SHALL suppress the memory write on an errored store; an errored request still completes the handshake with rsp_err=1 and rsp_rdata=0.
REQ-023 SHALL write stores in the acceptance cycle via byte enables: SB one lane from wdata[7:0], SH lanes {1,0} or {3,2} from wdata[15:0], SW all four lanes.
REQ-024 SHALL read loads synchronously at acceptance, then select lane(s) and sign-extend for B/H and zero-extend for BU/HU.
REQ-025 SHALL leave untouched lanes of the target word unchanged on sub-word stores.
REQ-026 SHALL make a load following a store to the same address return the newly stored data.
REQ-027 SHALL not initialise memory contents; reads of never-written words are don't-care.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, enter IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0; req_ready=1 in the cycle after.
REQ-029 SHALL leave memory contents unchanged by reset; a reset arriving in RESP drops the pending response.
REQ-030 SHALL block writes while rst=1 even if req_valid=1.

Structure
REQ-031 SHALL take funct3 size codes and the FSM state encoding from the shared CPU package, which the decoder also uses.
REQ-032 SHALL place lane select and extension in one combinational sub-module, load_align, reused by the load path.
REQ-033 SHALL infer memory as byte-enabled block RAM: four 8-bit lanes, DEPTH entries.

Verification
REQ-034 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, response 1 cycle after acceptance.
REQ-035 After that, SB 0x55 @0x12, then LW @0x10 -> 0xDE55BEEF; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
REQ-036 SH 0x8001 @0x20, then LH @0x20 -> 0xFFFF8001; LHU -> 0x00008001; LH @0x21 -> rsp_err=1, rsp_rdata=0.
REQ-037 SW 0x1 @0x32 (misaligned) -> rsp_err=1, and a following LW @0x30 shows the prior word unchanged; LW @(DEPTH*4) -> rsp_err=1.
REQ-038 Hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable, req_ready=0, new req_valid ignored.
REQ-039 Assert rst while in RESP -> next cycle rsp_valid=0, req_ready=1, and previously written memory still readable.

Source files
------------

// File: rtl/data_mem_be_pkg.sv
// data_mem_be_pkg: shared RV32I load/store size codes and memory FSM states
package data_mem_be_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;
endpackage

// File: rtl/data_mem_be_load_align.sv
// load_align: picks the addressed byte/half of a word and sign- or zero-extends it
module load_align
  import data_mem_be_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        uns;
  assign b   = word_i[{off_i, 3'b000} +: 8];
  assign h   = off_i[1] ? word_i[31:16] : word_i[15:0];
  assign uns = funct3_i[2];
  // funct3[1:0] gives the size, funct3[2] selects zero extension
  always_comb
    data_o = (funct3_i[1:0] == F3_B[1:0]) ? {{24{b[7] & ~uns}}, b} :
             (funct3_i[1:0] == F3_H[1:0]) ? {{16{h[15] & ~uns}}, h} : word_i;
endmodule

// File: rtl/data_mem_be.sv
// data_mem_be: byte-enabled data memory with valid/ready request and response handshakes
module data_mem_be
  import data_mem_be_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH) + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  logic [3:0][7:0] mem [DEPTH];
  state_e          state_q, state_d;
  logic            accept, err_d, we, err_q, ld_q;
  logic [AW-3:0]   idx;
  logic [1:0]      off, off_q;
  logic [2:0]      f3_q;
  logic [3:0]      be;
  logic [31:0]     wlane, raw_q, aligned;

  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign accept    = req_valid && req_ready && !rst;
  assign idx       = req_addr[AW-1:2];
  assign off       = req_addr[1:0];
  assign err_d     = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                     (req_we && req_funct3[2]) ||
                     ((req_funct3 == F3_H || req_funct3 == F3_HU) && off[0]) ||
                     (req_funct3 == F3_W && off != 2'b00) ||
                     (req_addr[31:AW] != '0);
  assign we        = accept && req_we && !err_d;
  assign be        = (req_funct3[1:0] == 2'b00) ? 4'b0001 << off :
                     (req_funct3[1:0] == 2'b01) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wlane     = (req_funct3[1:0] == 2'b00) ? {4{req_wdata[7:0]}} :
                     (req_funct3[1:0] == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;

  // next state: accept a request in IDLE, release the response in RESP
  always_comb
    state_d = (state_q == IDLE) ? (req_valid ? RESP : IDLE) : (rsp_ready ? IDLE : RESP);

  // handshake FSM; response attributes are captured only on acceptance so they hold in RESP
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= err_d;
        ld_q  <= !req_we && !err_d;
        off_q <= off;
        f3_q  <= req_funct3;
      end
    end

  // byte-lane block RAM: masked write and registered read in the acceptance cycle
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (we && be[l]) mem[idx][l] <= wlane[8*l +: 8];
    if (accept) raw_q <= mem[idx];
  end

  load_align u_align (
    .word_i   (raw_q),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  assign rsp_rdata = (rsp_valid && ld_q) ? aligned : '0;
  assign rsp_err   = rsp_valid && err_q;
endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: scoreboard-driven checks of loads, stores, errors, backpressure and reset
module tb_data_mem_be;
  localparam int DEPTH = 256;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [32:0] e;
  } op_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic [32:0] sb[$];
  logic [7:0]  mb [32];
  int          n_cmp = 0, n_fail = 0;

  localparam logic [32:0] ERR = {1'b1, 32'h0};
  localparam logic [32:0] OK0 = 33'h0;

  data_mem_be #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [32:0] exp, output logic [32:0] got, output int lat);
    @(negedge clk);
    drive(we, f3, a, wd);
    sb.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 8) begin
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout addr=%h got no response within 8 cycles", a);
    end
    got = {rsp_err, rsp_rdata};
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [32:0] e);
    int b;
    logic err;
    logic [31:0] r;
    err = f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]) || (f3[1:0] == 2'b01 && a[0]) ||
          (f3 == 3'b010 && a[1:0] != 2'b00) || a >= 32'(DEPTH * 4);
    b = int'(a) - 'h40;
    r = '0;
    if (!err && we) begin
      mb[b] = wd[7:0];
      if (f3 != 3'b000) mb[b+1] = wd[15:8];
      if (f3 == 3'b010) begin mb[b+2] = wd[23:16]; mb[b+3] = wd[31:24]; end
    end else if (!err)
      case (f3)
        3'b000:  r = {{24{mb[b][7]}}, mb[b]};
        3'b100:  r = {24'h0, mb[b]};
        3'b001:  r = {{16{mb[b+1][7]}}, mb[b+1], mb[b]};
        3'b101:  r = {16'h0, mb[b+1], mb[b]};
        default: r = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      endcase
    e = {err, r};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
  endtask

  task automatic test_word;
    logic [32:0] g, e;
    int l;
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, OK0, g, l);
    e = sb.pop_front();
    n_cmp++; if (g !== e) begin n_fail++; $display("FAIL sw_dead got=%h exp=%h", g, e); end
    xact(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, g, l);
    e = sb.pop_front();
    n_cmp++; if (g !== e) begin n_fail++; $display("FAIL lw_dead got=%h exp=%h", g, e); end
    n_cmp++; if (l !== 0) begin n_fail++; $display("FAIL lw_latency got=%0d exp=0 extra cycles", l); end
  endtask

  task automatic test_byte;
    op_t ops[4];
    logic [32:0] g, e;
    int l;
    ops = '{'{1'b1, 3'b000, 32'h12, 32'h55,  OK0},
            '{1'b0, 3'b010, 32'h10, 32'h0,   {1'b0, 32'hDE55BEEF}},
            '{1'b0, 3'b000, 32'h13, 32'h0,   {1'b0, 32'hFFFFFFDE}},
            '{1'b0, 3'b100, 32'h13, 32'h0,   {1'b0, 32'h000000DE}}};
    foreach (ops[i]) begin
      xact(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, ops[i].e, g, l);
      e = sb.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL byte[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_half;
    op_t ops[6];
    logic [32:0] g, e;
    int l;
    ops = '{'{1'b1, 3'b001, 32'h20, 32'hABCD8001, OK0},
            '{1'b0, 3'b001, 32'h20, 32'h0,        {1'b0, 32'hFFFF8001}},
            '{1'b0, 3'b101, 32'h20, 32'h0,        {1'b0, 32'h00008001}},
            '{1'b0, 3'b001, 32'h21, 32'h0,        ERR},
            '{1'b1, 3'b001, 32'h22, 32'h00001234, OK0},
            '{1'b0, 3'b010, 32'h20, 32'h0,        {1'b0, 32'h12348001}}};
    foreach (ops[i]) begin
      xact(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, ops[i].e, g, l);
      e = sb.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL half[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_errors;
    op_t ops[12];
    logic [32:0] g, e;
    int l;
    ops = '{'{1'b1, 3'b010, 32'h30,         32'hCAFEF00D, OK0},
            '{1'b1, 3'b010, 32'h32,         32'h1,        ERR},
            '{1'b0, 3'b010, 32'h30,         32'h0,        {1'b0, 32'hCAFEF00D}},
            '{1'b1, 3'b100, 32'h30,         32'hAA,       ERR},
            '{1'b1, 3'b001, 32'h31,         32'hFFFF,     ERR},
            '{1'b1, 3'b010, 32'h400,        32'h0,        ERR},
            '{1'b0, 3'b010, 32'h30,         32'h0,        {1'b0, 32'hCAFEF00D}},
            '{1'b0, 3'b010, 32'(DEPTH * 4), 32'h0,        ERR},
            '{1'b0, 3'b000, 32'h80000030,   32'h0,        ERR},
            '{1'b0, 3'b011, 32'h30,         32'h0,        ERR},
            '{1'b0, 3'b110, 32'h30,         32'h0,        ERR},
            '{1'b0, 3'b101, 32'h32,         32'h0,        {1'b0, 32'h0000CAFE}}};
    foreach (ops[i]) begin
      xact(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, ops[i].e, g, l);
      e = sb.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL err[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_backpressure;
    logic [32:0] g, e;
    int l;
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    sb.push_back({1'b0, 32'hDE55BEEF});
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 drive(1'b1, 3'b010, 32'h10, 32'h0);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready} !== 2'b10) begin
        n_fail++; $display("FAIL stall_hs[%0d] got valid/ready=%b exp=10", i, {rsp_valid, req_ready});
      end
      n_cmp++;
      if ({rsp_err, rsp_rdata} !== e) begin
        n_fail++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, {rsp_err, rsp_rdata}, e);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    xact(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'hDE55BEEF}, g, l);
    e = sb.pop_front();
    n_cmp++; if (g !== e) begin n_fail++; $display("FAIL stall_ignored_store got=%h exp=%h", g, e); end
  endtask

  task automatic test_reset_in_resp;
    logic [32:0] g, e;
    int l;
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h20, 32'h0);
    sb.push_back({1'b0, 32'h12348001});
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    e = sb.pop_front();
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {3'b010, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_in_resp got v/r/e/d=%b%b%b/%h exp=010/0", rsp_valid, req_ready, rsp_err, rsp_rdata);
    end
    xact(1'b0, 3'b010, 32'h20, 32'h0, {1'b0, 32'h12348001}, g, l);
    e = sb.pop_front();
    n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rst_mem_20 got=%h exp=%h", g, e); end
    xact(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'hDE55BEEF}, g, l);
    e = sb.pop_front();
    n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rst_mem_10 got=%h exp=%h", g, e); end
  endtask

  task automatic test_back_to_back;
    logic [32:0] g, e, m;
    logic [31:0] a, wd;
    logic [2:0]  f3;
    logic        we;
    int l;
    for (int i = 0; i < 68; i++) begin
      if (i < 8) begin
        we = 1'b1; f3 = 3'b010; a = 32'h40 + 32'(4 * i);
      end else begin
        we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7)); a = 32'h40 + 32'($urandom_range(0, 31));
      end
      wd = $urandom;
      model(we, f3, a, wd, m);
      xact(we, f3, a, wd, m, g, l);
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_fail++; $display("FAIL rand[%0d] we=%b f3=%b a=%h got=%h exp=%h", i, we, f3, a, g, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_backpressure;
    test_reset_in_resp;
    test_back_to_back;
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
